sif_addsub_flow: RTL
====================

// Module: sif_addsub_flow
// PURPOSE
//  Flow-control shell for the ready-less, fixed-latency FP add/sub core (sif_addsub).
//  Upstream: joins the A and B operand streams. Downstream: returns a real S_rdy
//  backpressure path. Tracks in-flight operations with credits and buffers results
//  in a FIFO, so no result is lost when the consumer stalls.
//  Sits between operand producers and the core (the core is instantiated beside this
//  block, not inside it).
// PARAMETERS
//  WIDTH    32  operand/result width; 16 or 32 (fp16/fp32 core)
//  LATENCY  8   core pipeline latency in cycles, core_vld -> core_S_vld
//  DEPTH    16  result FIFO entries; must be >= LATENCY+1 for one op/cycle
// PORTS
//  clk          in   1      single clock
//  rst          in   1      synchronous, active-high reset
//  is_sub       in   1      op select, qualified with the A/B pair (1 = A-B)
//  A_vld        in   1      operand A valid
//  A_dat        in   WIDTH  operand A data
//  A_rdy        out  1      operand A accepted
//  B_vld        in   1      operand B valid
//  B_dat        in   WIDTH  operand B data
//  B_rdy        out  1      operand B accepted
//  S_vld        out  1      result valid (FIFO head)
//  S_dat        out  WIDTH  result data
//  S_rdy        in   1      consumer ready
//  core_vld     out  1      drives both core s_axis_a/b_tvalid
//  core_A_dat   out  WIDTH  core operand A
//  core_B_dat   out  WIDTH  core operand B
//  core_is_sub  out  1      core operation select
//  core_S_vld   in   1      core result valid
//  core_S_dat   in   WIDTH  core result data
//  err          out  1      sticky: core result arrived with no credit or with FIFO full
// BEHAVIOUR
//  - Reset (rst=1 at posedge): S_vld=0, A_rdy=B_rdy=0, core_vld=0, err=0,
//    inflight=0, FIFO empty, FSM->FLUSH, flush_cnt=0.
//  - FSM FLUSH: A_rdy=B_rdy=0; core_S_vld ignored (no push, no err).
//    Exits to RUN after LATENCY cycles, discarding results still in the core from
//    before reset. This covers reset mid-operation.
//  - FSM RUN: credit = (inflight + fifo_cnt < DEPTH).
//  - Handshake: fire = A_vld & B_vld & credit & RUN.
//    A_rdy = B_vld & credit & RUN; B_rdy = A_vld & credit & RUN.
//    A_rdy/B_rdy never depend on their own valid.
//  - Core drive (combinational): core_vld = fire; core_A_dat = A_dat;
//    core_B_dat = B_dat; core_is_sub = is_sub.
//  - Counters: inflight_next = inflight + fire - (core_S_vld & RUN). Simultaneous
//    fire and return leaves inflight unchanged. Both counters are CNT_W = $clog2(DEPTH+1) bits.
//  - FIFO: push = core_S_vld & RUN. Pop = S_vld & S_rdy.
//    Push and pop in the same cycle is legal at any fill level, full included.
//    Show-ahead: S_vld rises the cycle after the first push into an empty FIFO.
//  - Total latency, fire to S_vld, = LATENCY+1 cycles when the FIFO is empty.
//    Sustained throughput is 1 op/cycle when S_rdy=1 and DEPTH >= LATENCY+1.
//  - Boundaries:
//    - Full: credit=0 deasserts A_rdy/B_rdy. No data is dropped.
//    - Empty: S_vld=0, S_dat holds its last value.
//    - Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
//  - err: set on core_S_vld in RUN with inflight==0, or on push with FIFO full and no
//    pop. Cleared only by rst. Data is dropped in the error case.
//  - S_vld/S_dat stay stable while S_vld & ~S_rdy.
// STRUCTURE
//  - Package sif_pkg:
//    - typedef enum logic {FLUSH, RUN} sif_flow_st_t
//    - function clog2_p1(n) for counter widths
//    - localparam SIF_FP32_W=32, SIF_FP16_W=16
//  - Sub-module sif_sync_fifo #(WIDTH, DEPTH): push/pop/full/empty/count,
//    synchronous active-high rst.
//  - Top holds the FSM, flush counter, inflight counter, join logic and err.
//  - Elaboration assertion: DEPTH >= 1 and LATENCY >= 1.
// TESTING (bench uses a behavioural core model: LATENCY-stage delay line of a+b / a-b)
//  1. Reset, then hold A_vld=B_vld=1 -> A_rdy=0 for 8 cycles (FLUSH), asserts in
//     cycle 9. Stale core_S_vld pulses injected during FLUSH -> no S_vld, err=0.
//  2. A=0x3F800000, B=0x40000000, is_sub=0, S_rdy=1 -> S_dat=0x40400000 exactly 9 cycles
//     after fire. With is_sub=1 -> 0xBF800000.
//  3. 40 back-to-back pairs, S_rdy=1 -> 40 results in order, A_rdy never drops, no gaps
//     after the first result.
//  4. S_rdy=0, stream pairs -> exactly 16 fires, then A_rdy=B_rdy=0. Raise S_rdy -> 16
//     results in order, S_dat stable while stalled, traffic resumes.
//  5. A_vld=1 with B_vld=0 for 5 cycles -> A_rdy=0, core_vld=0. B_vld rises -> one fire,
//     both rdy high in the same cycle.
//  6. Assert rst mid-stream with 5 ops in flight -> S_vld=0 the next cycle. The 5 stale
//     results are swallowed in FLUSH, err=0. The first post-reset op returns the correct value.

Source files
------------

// File: rtl/sif_pkg.sv
// sif_pkg: shared state type, widths and counter-width helper for the add/sub flow shell.
package sif_pkg;
    localparam int SIF_FP32_W = 32;
    localparam int SIF_FP16_W = 16;

    typedef enum logic {FLUSH, RUN} sif_flow_st_t;

    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/sif_addsub_flow_if.sv
// sif_addsub_flow_if: operand join, result stream, core drive/return and error flag.
interface sif_addsub_flow_if #(
    parameter int WIDTH = 32
);
    logic             is_sub;
    logic             A_vld;
    logic [WIDTH-1:0] A_dat;
    logic             A_rdy;
    logic             B_vld;
    logic [WIDTH-1:0] B_dat;
    logic             B_rdy;
    logic             S_vld;
    logic [WIDTH-1:0] S_dat;
    logic             S_rdy;
    logic             core_vld;
    logic [WIDTH-1:0] core_A_dat;
    logic [WIDTH-1:0] core_B_dat;
    logic             core_is_sub;
    logic             core_S_vld;
    logic [WIDTH-1:0] core_S_dat;
    logic             err;

    modport slave (
        input  is_sub, A_vld, A_dat, B_vld, B_dat, S_rdy, core_S_vld, core_S_dat,
        output A_rdy, B_rdy, S_vld, S_dat, core_vld, core_A_dat, core_B_dat, core_is_sub, err
    );

    modport master (
        output is_sub, A_vld, A_dat, B_vld, B_dat, S_rdy, core_S_vld, core_S_dat,
        input  A_rdy, B_rdy, S_vld, S_dat, core_vld, core_A_dat, core_B_dat, core_is_sub, err
    );
endinterface

// File: rtl/sif_sync_fifo.sv
// sif_sync_fifo: show-ahead synchronous FIFO, any DEPTH; output holds last popped word when empty.
module sif_sync_fifo
    import sif_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_dat,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [clog2_p1(DEPTH)-1:0] o_cnt
);
    localparam int CNT_W = clog2_p1(DEPTH);
    localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr, r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             w_push, w_pop;

    assign o_empty = r_cnt == '0;
    assign o_full  = r_cnt == CNT_W'(DEPTH);
    assign o_cnt   = r_cnt;
    assign w_pop   = i_pop & ~o_empty;
    // a pop frees the head slot, so a push into a full FIFO is accepted alongside it
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_dat   = o_empty ? r_hold : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_hold <= '0;
        end else begin
            if (w_push) r_wr <= r_wr == PW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd == PW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
            if (w_pop) r_hold <= r_mem[r_rd];
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/sif_addsub_flow.sv
// sif_addsub_flow: joins A/B operands into a fixed-latency add/sub core and buffers its
// results behind a credit-guarded FIFO so the consumer can stall without losing data.
module sif_addsub_flow
    import sif_pkg::*;
#(
    parameter int WIDTH   = SIF_FP32_W,
    parameter int LATENCY = 8,
    parameter int DEPTH   = 16
) (
    input logic              clk,
    input logic              rst,
    sif_addsub_flow_if.slave bus
);
    localparam int CNT_W = clog2_p1(DEPTH);
    localparam int FL_W  = clog2_p1(LATENCY);

    if (DEPTH < 1 || LATENCY < 1) begin : g_bad_param
        $error("sif_addsub_flow: DEPTH and LATENCY must both be >= 1");
    end

    sif_flow_st_t     r_st, w_st_nxt;
    logic [FL_W-1:0]  r_flush_cnt;
    logic [CNT_W-1:0] r_inflight, w_fifo_cnt;
    logic             r_err;
    logic             w_run, w_credit, w_fire, w_ret, w_push, w_pop, w_full, w_empty;

    assign w_run    = r_st == RUN;
    assign w_credit = ({1'b0, r_inflight} + {1'b0, w_fifo_cnt}) < (CNT_W + 1)'(DEPTH);
    assign w_fire   = bus.A_vld & bus.B_vld & w_credit & w_run;
    assign w_ret    = bus.core_S_vld & w_run;
    // a return with nothing in flight is spurious: flag it and drop the data
    assign w_push   = w_ret & (r_inflight != '0);
    assign w_pop    = bus.S_vld & bus.S_rdy;

    assign bus.A_rdy       = bus.B_vld & w_credit & w_run;
    assign bus.B_rdy       = bus.A_vld & w_credit & w_run;
    assign bus.core_vld    = w_fire;
    assign bus.core_A_dat  = bus.A_dat;
    assign bus.core_B_dat  = bus.B_dat;
    assign bus.core_is_sub = bus.is_sub;
    assign bus.S_vld       = ~w_empty;
    assign bus.err         = r_err;

    sif_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (bus.core_S_dat),
        .i_pop   (w_pop),
        .o_dat   (bus.S_dat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (w_fifo_cnt)
    );

    // FLUSH lasts LATENCY cycles so results issued before reset drain out unseen
    always_comb begin
        w_st_nxt = (r_st == FLUSH && r_flush_cnt == FL_W'(LATENCY - 1)) ? RUN : r_st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st        <= FLUSH;
            r_flush_cnt <= '0;
            r_inflight  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_st        <= w_st_nxt;
            r_flush_cnt <= w_run ? r_flush_cnt : r_flush_cnt + 1'b1;
            r_inflight  <= r_inflight + CNT_W'(w_fire) - CNT_W'(w_push);
            r_err       <= r_err | (w_ret & (r_inflight == '0)) | (w_push & w_full & ~w_pop);
        end
    end
endmodule
